// File: rtl/icm_miss_handler.sv
// Miss handler behind the ICM cache buffer: forwards hits, fetches misses over DMA,
// then writes the fetched entry back into the buffer and returns it to the requester.
module icm_miss_handler #(
  parameter int unsigned ICM_ADDR_WIDTH      = 64,
  parameter int unsigned PHYSICAL_ADDR_WIDTH = 64,
  parameter int unsigned META_WIDTH          = 12,
  parameter int unsigned CACHE_ADDR_WIDTH    = 20,
  parameter int unsigned CACHE_ENTRY_WIDTH   = 256,
  parameter int unsigned REQ_TAG_NUM         = 32,
  parameter int unsigned REQ_TAG_NUM_LOG     = 5
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                get_rsp_valid,
  input  logic [META_WIDTH+PHYSICAL_ADDR_WIDTH+ICM_ADDR_WIDTH:0] get_rsp_head,
  input  logic [CACHE_ENTRY_WIDTH-1:0]                        get_rsp_data,
  output logic                                                get_rsp_ready,
  output logic                                                dma_rd_req_valid,
  output logic [REQ_TAG_NUM_LOG+32+PHYSICAL_ADDR_WIDTH-1:0]   dma_rd_req_head,
  input  logic                                                dma_rd_req_ready,
  input  logic                                                dma_rd_rsp_valid,
  input  logic [REQ_TAG_NUM_LOG-1:0]                          dma_rd_rsp_tag,
  input  logic [CACHE_ENTRY_WIDTH-1:0]                        dma_rd_rsp_data,
  output logic                                                dma_rd_rsp_ready,
  output logic                                                set_req_valid,
  output logic [CACHE_ADDR_WIDTH-1:0]                         set_req_head,
  output logic [CACHE_ENTRY_WIDTH-1:0]                        set_req_data,
  input  logic                                                set_req_ready,
  output logic                                                out_valid,
  output logic [META_WIDTH+ICM_ADDR_WIDTH-1:0]                out_head,
  output logic [CACHE_ENTRY_WIDTH-1:0]                        out_data,
  input  logic                                                out_ready
);

  localparam int unsigned HEAD_W = 1 + META_WIDTH + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH;
  localparam int unsigned CNT_W  = REQ_TAG_NUM_LOG + 1;
  localparam int unsigned BYTE_LEN = CACHE_ENTRY_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, HIT_OUT, MISS_REQ, FILL} state_t;

  state_t                         state;
  logic [REQ_TAG_NUM_LOG-1:0]     free_list [REQ_TAG_NUM];
  logic [REQ_TAG_NUM_LOG-1:0]     rd_ptr;
  logic [REQ_TAG_NUM_LOG-1:0]     wr_ptr;
  logic [CNT_W-1:0]               free_cnt;
  logic [REQ_TAG_NUM-1:0]         ctx_valid;
  logic [META_WIDTH-1:0]          ctx_meta [REQ_TAG_NUM];
  logic [ICM_ADDR_WIDTH-1:0]      ctx_icm  [REQ_TAG_NUM];
  logic [REQ_TAG_NUM_LOG-1:0]     fill_tag;
  logic                           set_done;
  logic                           out_done;
  logic                           err_unknown_tag;

  logic                           in_hit;
  logic [META_WIDTH-1:0]          in_meta;
  logic [PHYSICAL_ADDR_WIDTH-1:0] in_phy;
  logic [ICM_ADDR_WIDTH-1:0]      in_icm;
  logic [REQ_TAG_NUM_LOG-1:0]     pop_tag;
  logic [META_WIDTH-1:0]          rsp_meta;
  logic [ICM_ADDR_WIDTH-1:0]      rsp_icm;
  logic                           set_done_n;
  logic                           out_done_n;

  assign in_hit     = get_rsp_head[HEAD_W-1];
  assign in_meta    = get_rsp_head[HEAD_W-2 -: META_WIDTH];
  assign in_phy     = get_rsp_head[ICM_ADDR_WIDTH +: PHYSICAL_ADDR_WIDTH];
  assign in_icm     = get_rsp_head[ICM_ADDR_WIDTH-1:0];
  assign pop_tag    = free_list[rd_ptr];
  assign rsp_meta   = ctx_meta[dma_rd_rsp_tag];
  assign rsp_icm    = ctx_icm[dma_rd_rsp_tag];
  assign set_done_n = set_done | (set_req_valid & set_req_ready);
  assign out_done_n = out_done | (out_valid & out_ready);

  // Ready outputs are registered: IDLE raises one of them for a single cycle,
  // choosing the DMA response over a new buffer response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      get_rsp_ready    <= 1'b0;
      dma_rd_req_valid <= 1'b0;
      dma_rd_req_head  <= '0;
      dma_rd_rsp_ready <= 1'b0;
      set_req_valid    <= 1'b0;
      set_req_head     <= '0;
      set_req_data     <= '0;
      out_valid        <= 1'b0;
      out_head         <= '0;
      out_data         <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      free_cnt         <= CNT_W'(REQ_TAG_NUM);
      ctx_valid        <= '0;
      fill_tag         <= '0;
      set_done         <= 1'b0;
      out_done         <= 1'b0;
      err_unknown_tag  <= 1'b0;
      for (int i = 0; i < int'(REQ_TAG_NUM); i++) begin
        free_list[i] <= REQ_TAG_NUM_LOG'(i);
        ctx_meta[i]  <= '0;
        ctx_icm[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (get_rsp_ready && get_rsp_valid) begin
            get_rsp_ready <= 1'b0;
            if (in_hit) begin
              out_head <= {in_meta, in_icm};
              out_data <= get_rsp_data;
              state    <= HIT_OUT;
            end else begin
              dma_rd_req_valid   <= 1'b1;
              dma_rd_req_head    <= {pop_tag, 32'(BYTE_LEN), in_phy};
              ctx_valid[pop_tag] <= 1'b1;
              ctx_meta[pop_tag]  <= in_meta;
              ctx_icm[pop_tag]   <= in_icm;
              rd_ptr             <= rd_ptr + REQ_TAG_NUM_LOG'(1);
              free_cnt           <= free_cnt - CNT_W'(1);
              state              <= MISS_REQ;
            end
          end else if (dma_rd_rsp_ready && dma_rd_rsp_valid) begin
            dma_rd_rsp_ready <= 1'b0;
            if (ctx_valid[dma_rd_rsp_tag]) begin
              fill_tag      <= dma_rd_rsp_tag;
              set_req_valid <= 1'b1;
              set_req_head  <= rsp_icm[CACHE_ADDR_WIDTH-1:0];
              set_req_data  <= dma_rd_rsp_data;
              out_valid     <= 1'b1;
              out_head      <= {rsp_meta, rsp_icm};
              out_data      <= dma_rd_rsp_data;
              set_done      <= 1'b0;
              out_done      <= 1'b0;
              state         <= FILL;
            end else begin
              err_unknown_tag <= 1'b1;
            end
          end else begin
            dma_rd_rsp_ready <= dma_rd_rsp_valid;
            get_rsp_ready    <= !dma_rd_rsp_valid && get_rsp_valid &&
                                (in_hit || free_cnt != '0);
          end
        end
        // One idle cycle before raising out_valid on the hit path.
        HIT_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MISS_REQ: begin
          if (dma_rd_req_ready) begin
            dma_rd_req_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        FILL: begin
          if (set_req_valid && set_req_ready) set_req_valid <= 1'b0;
          if (out_valid && out_ready) out_valid <= 1'b0;
          set_done <= set_done_n;
          out_done <= out_done_n;
          if (set_done_n && out_done_n) begin
            free_list[wr_ptr]   <= fill_tag;
            wr_ptr              <= wr_ptr + REQ_TAG_NUM_LOG'(1);
            free_cnt            <= free_cnt + CNT_W'(1);
            ctx_valid[fill_tag] <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icm_miss_handler.sv
// Directed bench for icm_miss_handler: hit vector table plus hand-written
// miss / fill / tag-exhaustion / priority / reset sequences.
module tb_icm_miss_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic         get_rsp_valid;
  logic [140:0] get_rsp_head;
  logic [255:0] get_rsp_data;
  logic         get_rsp_ready;
  logic         dma_rd_req_valid;
  logic [100:0] dma_rd_req_head;
  logic         dma_rd_req_ready;
  logic         dma_rd_rsp_valid;
  logic [4:0]   dma_rd_rsp_tag;
  logic [255:0] dma_rd_rsp_data;
  logic         dma_rd_rsp_ready;
  logic         set_req_valid;
  logic [19:0]  set_req_head;
  logic [255:0] set_req_data;
  logic         set_req_ready;
  logic         out_valid;
  logic [75:0]  out_head;
  logic [255:0] out_data;
  logic         out_ready;

  int n_pass  = 0;
  int n_total = 0;

  icm_miss_handler dut (
    .clk(clk), .rst(rst),
    .get_rsp_valid(get_rsp_valid), .get_rsp_head(get_rsp_head),
    .get_rsp_data(get_rsp_data), .get_rsp_ready(get_rsp_ready),
    .dma_rd_req_valid(dma_rd_req_valid), .dma_rd_req_head(dma_rd_req_head),
    .dma_rd_req_ready(dma_rd_req_ready),
    .dma_rd_rsp_valid(dma_rd_rsp_valid), .dma_rd_rsp_tag(dma_rd_rsp_tag),
    .dma_rd_rsp_data(dma_rd_rsp_data), .dma_rd_rsp_ready(dma_rd_rsp_ready),
    .set_req_valid(set_req_valid), .set_req_head(set_req_head),
    .set_req_data(set_req_data), .set_req_ready(set_req_ready),
    .out_valid(out_valid), .out_head(out_head), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  meta;
    logic [63:0]  icm;
    logic [255:0] data;
    logic [75:0]  exp_head;
  } hit_vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_get(input logic hit, input logic [11:0] meta,
                           input logic [63:0] phy, input logic [63:0] icm,
                           input logic [255:0] data);
    get_rsp_head  = {hit, meta, phy, icm};
    get_rsp_data  = data;
    get_rsp_valid = 1'b1;
  endtask

  task automatic wait_get_accept(input string name);
    logic hs;
    int   ok;
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      hs = get_rsp_ready && get_rsp_valid;
      tick();
      if (hs) ok = 1;
    end
    get_rsp_valid = 1'b0;
    chk(name, 256'(ok), 256'(1));
  endtask

  task automatic get_txn(input string name, input logic hit, input logic [11:0] meta,
                         input logic [63:0] phy, input logic [63:0] icm,
                         input logic [255:0] data);
    drive_get(hit, meta, phy, icm, data);
    wait_get_accept(name);
  endtask

  task automatic dma_rsp(input string name, input logic [4:0] tag, input logic [255:0] data);
    logic hs;
    int   ok;
    dma_rd_rsp_tag   = tag;
    dma_rd_rsp_data  = data;
    dma_rd_rsp_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      hs = dma_rd_rsp_ready && dma_rd_rsp_valid;
      tick();
      if (hs) ok = 1;
    end
    dma_rd_rsp_valid = 1'b0;
    chk(name, 256'(ok), 256'(1));
  endtask

  // Cycles counted from the accept edge: 1 = visible right after that edge.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic reset_dut(input string name);
    rst = 1'b0;
    tick();
    tick();
    chk({name, "_get_ready"}, 256'(get_rsp_ready), 256'(0));
    chk({name, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({name, "_out_data"}, out_data, 256'(0));
    chk({name, "_dma_req_valid"}, 256'(dma_rd_req_valid), 256'(0));
    chk({name, "_set_valid"}, 256'(set_req_valid), 256'(0));
    chk({name, "_free_cnt"}, 256'(dut.free_cnt), 256'(32));
    rst = 1'b1;
    tick();
  endtask

  hit_vec_t hv [4];

  initial begin
    int           lat;
    logic         seen;
    logic         bad;
    logic [255:0] d;

    rst = 1'b0; get_rsp_valid = 1'b0; get_rsp_head = '0; get_rsp_data = '0;
    dma_rd_req_ready = 1'b1; dma_rd_rsp_valid = 1'b0; dma_rd_rsp_tag = '0;
    dma_rd_rsp_data = '0; set_req_ready = 1'b1; out_ready = 1'b1;

    hv[0] = '{12'h0A5, 64'h1000, {8{32'hDEAD_BEEF}}, {12'h0A5, 64'h1000}};
    hv[1] = '{12'hFFF, 64'hFFFF_FFFF_FFFF_FFC0, {256{1'b1}}, {12'hFFF, 64'hFFFF_FFFF_FFFF_FFC0}};
    hv[2] = '{12'h000, 64'h0, 256'h0, {12'h000, 64'h0}};
    hv[3] = '{12'h123, 64'h0000_1234_5678_9ABC, {4{64'h0123_4567_89AB_CDEF}},
              {12'h123, 64'h0000_1234_5678_9ABC}};

    reset_dut("reset0");

    // Hits: out_valid two cycles after accept, never a DMA read or set.
    for (int i = 0; i < 4; i++) begin
      get_txn("hit_accept", 1'b1, hv[i].meta, 64'h5555_0000, hv[i].icm, hv[i].data);
      wait_out(lat);
      chk("hit_latency", 256'(lat), 256'(2));
      chk("hit_out_head", 256'(out_head), 256'(hv[i].exp_head));
      chk("hit_out_data", out_data, hv[i].data);
      chk("hit_no_dma", 256'(dma_rd_req_valid), 256'(0));
      chk("hit_no_set", 256'(set_req_valid), 256'(0));
      tick();
      chk("hit_out_drop", 256'(out_valid), 256'(0));
    end

    // Basic miss then fill for tag 0.
    get_txn("miss0_accept", 1'b0, 12'h3C1, 64'h8000_0000, 64'h2040, '0);
    chk("miss0_req_valid", 256'(dma_rd_req_valid), 256'(1));
    chk("miss0_req_head", 256'(dma_rd_req_head), 256'({5'd0, 32'd32, 64'h8000_0000}));
    tick();
    chk("miss0_req_drop", 256'(dma_rd_req_valid), 256'(0));
    d = {8{32'hE0E1_E2E3}};
    dma_rsp("fill0_accept", 5'd0, d);
    chk("fill0_set_valid", 256'(set_req_valid), 256'(1));
    chk("fill0_out_valid", 256'(out_valid), 256'(1));
    chk("fill0_set_head", 256'(set_req_head), 256'(20'h02040));
    chk("fill0_set_data", set_req_data, d);
    chk("fill0_out_head", 256'(out_head), 256'({12'h3C1, 64'h2040}));
    chk("fill0_out_data", out_data, d);
    tick();
    chk("fill0_set_drop", 256'(set_req_valid), 256'(0));
    chk("fill0_out_drop", 256'(out_valid), 256'(0));
    chk("fill0_free_cnt", 256'(dut.free_cnt), 256'(32));

    // Response for a tag with no context is swallowed.
    dma_rsp("unknown_accept", 5'd9, {8{32'h0BAD_0BAD}});
    tick(); tick();
    chk("unknown_no_out", 256'(out_valid), 256'(0));
    chk("unknown_no_set", 256'(set_req_valid), 256'(0));
    chk("unknown_err", 256'(dut.err_unknown_tag), 256'(1));

    // Fill with out_ready held low: set completes alone, out holds, FSM stays in FILL.
    get_txn("miss1_accept", 1'b0, 12'h2AA, 64'h9000_0040, 64'h0123_4567, '0);
    chk("miss1_req_head", 256'(dma_rd_req_head), 256'({5'd1, 32'd32, 64'h9000_0040}));
    tick();
    out_ready = 1'b0;
    d = {4{64'hF00D_CAFE_1234_5678}};
    dma_rsp("fill1_accept", 5'd1, d);
    chk("fill1_set_head", 256'(set_req_head), 256'(20'h34567));
    drive_get(1'b1, 12'h0C3, 64'h0, 64'h3000, {8{32'h1111_2222}});
    bad = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (set_req_valid || !out_valid || out_data !== d || out_head !== {12'h2AA, 64'h0123_4567})
        bad = 1'b1;
      if (get_rsp_ready) seen = 1'b1;
    end
    chk("fill1_out_stable", 256'(bad), 256'(0));
    chk("fill1_stays_busy", 256'(seen), 256'(0));
    out_ready = 1'b1;
    tick();
    chk("fill1_out_drop", 256'(out_valid), 256'(0));
    wait_get_accept("fill1_next_hit_accept");
    wait_out(lat);
    chk("fill1_next_hit_head", 256'(out_head), 256'({12'h0C3, 64'h3000}));
    tick();

    // Exhaust all 32 tags.
    reset_dut("reset1");
    for (int i = 0; i < 32; i++) begin
      get_txn("fill_tags_accept", 1'b0, 12'h100 + 12'(i), 64'hA000_0000 + 64'(i * 64),
              64'h4_0000 + 64'(i * 'h40), '0);
      chk("fill_tags_req_head", 256'(dma_rd_req_head),
          256'({5'(i), 32'd32, 64'hA000_0000 + 64'(i * 64)}));
      tick();
    end
    drive_get(1'b0, 12'h1FF, 64'hB000_0000, 64'h5_0000, '0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (get_rsp_ready) seen = 1'b1;
      tick();
    end
    chk("full_holds_ready_low", 256'(seen), 256'(0));
    d = {8{32'h7777_0007}};
    dma_rsp("tag7_accept", 5'd7, d);
    chk("tag7_set_head", 256'(set_req_head), 256'(20'h401C0));
    chk("tag7_out_head", 256'(out_head), 256'({12'h107, 64'h4_01C0}));
    tick();
    wait_get_accept("miss33_accept");
    chk("miss33_req_head", 256'(dma_rd_req_head), 256'({5'd7, 32'd32, 64'hB000_0000}));
    tick();

    // Hit and DMA response together: DMA wins, hit follows.
    drive_get(1'b1, 12'h0EE, 64'h0, 64'h7000, {8{32'hABCD_0123}});
    dma_rd_rsp_tag   = 5'd3;
    dma_rd_rsp_data  = {8{32'h3333_3333}};
    dma_rd_rsp_valid = 1'b1;
    seen = 1'b0;
    bad  = 1'b1;
    for (int k = 0; k < 40 && bad; k++) begin
      logic hs;
      if (get_rsp_ready) seen = 1'b1;
      hs = dma_rd_rsp_ready && dma_rd_rsp_valid;
      tick();
      if (hs) bad = 1'b0;
    end
    dma_rd_rsp_valid = 1'b0;
    chk("prio_dma_accept", 256'(bad), 256'(0));
    chk("prio_get_held", 256'(seen), 256'(0));
    chk("prio_fill_head", 256'(out_head), 256'({12'h103, 64'h4_00C0}));
    chk("prio_fill_data", out_data, {8{32'h3333_3333}});
    tick();
    wait_get_accept("prio_hit_accept");
    wait_out(lat);
    chk("prio_hit_head", 256'(out_head), 256'({12'h0EE, 64'h7000}));
    chk("prio_hit_data", out_data, {8{32'hABCD_0123}});
    tick();

    // Reset while FILL is stalled.
    out_ready = 1'b0;
    set_req_ready = 1'b0;
    dma_rsp("rstfill_accept", 5'd5, {8{32'h5555_AAAA}});
    chk("rstfill_valids_up", 256'({set_req_valid, out_valid}), 256'(2'b11));
    rst = 1'b0;
    tick();
    chk("rstfill_out_valid", 256'(out_valid), 256'(0));
    chk("rstfill_set_valid", 256'(set_req_valid), 256'(0));
    chk("rstfill_free_cnt", 256'(dut.free_cnt), 256'(32));
    rst = 1'b1;
    out_ready = 1'b1;
    set_req_ready = 1'b1;
    tick();
    get_txn("rstfill_miss_accept", 1'b0, 12'h055, 64'hC000_0000, 64'h9000, '0);
    chk("rstfill_miss_head", 256'(dma_rd_req_head), 256'({5'd0, 32'd32, 64'hC000_0000}));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
